seq_divider_param: RTL and testbench
====================================

Name: seq_divider_param

Overview:
Parametrised multi-cycle radix-2 restoring divider, the next generation of the 8-bit Start/Busy divider used under TOP.
- Generalised to WIDTH bits.
- Adds a per-operation signed/unsigned mode, a one-cycle Done pulse and divide-by-zero handling.
- Sits behind a Start/Busy handshake driven by a controller or testbench.
- Results are registered and held until the next operation completes.

Parameters:
WIDTH, 8, operand/result width in bits (must be >= 2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start
InA  input  WIDTH  dividend; sampled with Start
InB  input  WIDTH  divisor; sampled with Start
Out_Q  output  WIDTH  quotient, registered
Out_R  output  WIDTH  remainder, registered
Busy  output  1  high while an operation is in progress
Done  output  1  single-cycle pulse when Out_Q/Out_R are updated
DivZero  output  1  registered; set with Done when InB was 0 (feature-dependent)

Behaviour:
- Reset (async, rst=1): state IDLE; Out_Q=0, Out_R=0, Busy=0, Done=0, DivZero=0; all internal registers cleared. Asserting rst mid-operation aborts it; no Done is issued.
- States and transitions:
  - IDLE: waits for Start. Start=1 at a rising edge captures InA, InB and Signed_Mode, then goes to LOAD.
  - LOAD (1 cycle): converts operands to magnitudes. In signed mode, a negative operand is replaced by its two's complement. Records sQ = signA xor signB and sR = signA. Clears the partial remainder (WIDTH+1 bits) and the step counter.
  - CALC (exactly WIDTH cycles, MSB first):
    - Shift {rem, dividend} left by 1.
    - Compute trial = rem - divisor.
    - If trial is non-negative: rem = trial and quotient bit = 1; otherwise quotient bit = 0.
    - Counter runs 0..WIDTH-1.
  - FIX (1 cycle): Out_Q = sQ ? -qmag : qmag and Out_R = sR ? -rmag : rmag, both truncated to WIDTH. In unsigned mode the magnitudes are written unchanged.
  - DONE (1 cycle): Done=1, then returns to IDLE.
- Timing:
  - Busy=1 in LOAD, CALC and FIX: exactly WIDTH+2 cycles, starting the cycle after Start is sampled.
  - Done is high in the first cycle after Busy falls, and outputs are valid from that cycle.
  - Minimum Start-to-Start spacing is WIDTH+3 cycles.
- Start during Busy or DONE is ignored and not queued. Start held high across DONE→IDLE begins a new operation at the first IDLE edge.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed overflow (most-negative / -1) yields Out_Q = most-negative value (e.g. 0x80), Out_R=0, with no flag.
- Out_Q/Out_R change only in FIX and hold otherwise. DivZero updates in FIX and holds.

Optional Feature:
Macro DIV_ZERO_CHECK_EN.
- Defined: InB==0 is detected in LOAD and the FSM jumps directly to DONE, so Busy lasts 1 cycle. Results: Out_Q = all ones, Out_R = InA as captured (raw, no sign fix), DivZero=1. A non-zero divisor gives DivZero=0.
- Undefined: no detection; the full algorithm runs (WIDTH+2 cycles).
  - Unsigned: Out_Q = all ones, Out_R = InA.
  - Signed: the magnitudes all-ones and |InA| pass through the normal FIX rule.
  - DivZero is tied 0.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, LOAD, CALC, FIX, DONE);
  - the state-width localparam;
  - a counter-width function clog2(WIDTH).
- One natural sub-module, div_step: combinational single restoring step. Inputs are rem, divisor and the incoming dividend bit; outputs are next rem and the quotient bit. It is instantiated once and used iteratively.

Test Plan:
- Unsigned, WIDTH=8: InA=0x55, InB=0x05 → Out_Q=0x11, Out_R=0x00; Busy high 10 cycles, Done 1 cycle.
- Unsigned: 0x85/0x15 → Q=0x06, R=0x07. 0xFF/0x05 → Q=0x33, R=0x00. 0x83/0x0F → Q=0x08, R=0x0B.
- Signed: 0x99(-103)/0x0E(14) → Q=0xF9(-7), R=0xFB(-5). 0x80/0xFF → Q=0x80, R=0x00.
- Divide by zero, 0x55/0x00:
  - with DIV_ZERO_CHECK_EN: Busy 1 cycle, Q=0xFF, R=0x55, DivZero=1;
  - without: Busy 10 cycles, same Q/R, DivZero=0.
- Start pulsed mid-CALC: ignored, and the first result is unchanged. rst pulsed mid-CALC: outputs 0 at once, no Done, and the next Start works normally.
- WIDTH=16 instance: 0xFFFF/0x0003 unsigned → Q=0x5555, R=0x0000; Busy 18 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// State encoding, state width and counter sizing.
package div_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, try subtract.
// Purely combinational; reused every CALC cycle.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted  = {rem[WIDTH-1:0], dvd_bit};
        trial    = {1'b0, shifted} - {2'b00, divisor};
        q_bit    = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/seq_divider_param.sv
// WIDTH-bit Start/Busy restoring divider, signed or unsigned per operation.
// Define DIV_ZERO_CHECK_EN to short-circuit zero divisors and raise DivZero.
module seq_divider_param
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    output logic [WIDTH-1:0] Out_Q,
    output logic [WIDTH-1:0] Out_R,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = clog2(WIDTH);

    state_t           state, nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] dvd, dvs;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic [WIDTH:0]   rem, rem_nx;
    logic [CW-1:0]    cnt;
    logic             sm_reg, sq, sr;
    logic             q_bit, a_neg, b_neg, last;

    assign a_neg = sm_reg & a_reg[WIDTH-1];
    assign b_neg = sm_reg & b_reg[WIDTH-1];
    assign last  = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_CHECK_EN
    logic b_zero;
    logic dz_reg;
    assign b_zero  = (b_reg == '0);
    assign DivZero = dz_reg;
`else
    assign DivZero = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (dvs),
        .dvd_bit  (dvd[WIDTH-1]),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (Start) nxt = LOAD;
`ifdef DIV_ZERO_CHECK_EN
            LOAD: nxt = b_zero ? DONE : CALC;
`else
            LOAD: nxt = CALC;
`endif
            CALC: if (last) nxt = FIX;
            FIX:  nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            sm_reg <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            q_reg  <= '0;
            r_reg  <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dz_reg <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg  <= InA;
                        b_reg  <= InB;
                        sm_reg <= Signed_Mode;
                    end
                end
                LOAD: begin
                    dvd <= a_neg ? -a_reg : a_reg;
                    dvs <= b_neg ? -b_reg : b_reg;
                    sq  <= a_neg ^ b_neg;
                    sr  <= a_neg;
                    rem <= '0;
                    cnt <= '0;
`ifdef DIV_ZERO_CHECK_EN
                    // Zero divisor skips CALC/FIX; raw dividend is the remainder.
                    if (b_zero) begin
                        q_reg  <= '1;
                        r_reg  <= a_reg;
                        dz_reg <= 1'b1;
                    end
`endif
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    q_reg <= sq ? -dvd : dvd;
                    r_reg <= sr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
                    dz_reg <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign Out_Q = q_reg;
    assign Out_R = r_reg;
    assign Busy  = (state == LOAD) | (state == CALC) | (state == FIX);
    assign Done  = (state == DONE);

endmodule

// File: tb/tb_seq_divider_param.sv
// Scoreboard bench for seq_divider_param at WIDTH=8 and WIDTH=16.
// Expected results come from a behavioural division model.
module tb_seq_divider_param;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic        busy8, done8, dz8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, q16, r16;
    logic        busy16, done16, dz16;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_divider_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .Start(start8), .Signed_Mode(sm8),
        .InA(a8), .InB(b8), .Out_Q(q8), .Out_R(r8),
        .Busy(busy8), .Done(done8), .DivZero(dz8)
    );

    seq_divider_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .Start(start16), .Signed_Mode(sm16),
        .InA(a16), .InB(b16), .Out_Q(q16), .Out_R(r16),
        .Busy(busy16), .Done(done16), .DivZero(dz16)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                    input logic sm);
        exp_t e;
        int sa, sb_, qi, ri;
        e.dz   = 1'b0;
        e.busy = 10;
`ifdef DIV_ZERO_CHECK_EN
        if (b == 8'h00) begin
            e.q = 32'hFF; e.r = {24'h0, a}; e.dz = 1'b1; e.busy = 1;
            return e;
        end
`endif
        if (!sm) begin
            if (b == 8'h00) begin qi = 255; ri = int'(a); end
            else begin qi = int'(a) / int'(b); ri = int'(a) % int'(b); end
        end else begin
            sa  = int'($signed(a));
            sb_ = int'($signed(b));
            if (b == 8'h00) begin
                qi = (sa < 0) ? -255 : 255;
                ri = sa;
            end else begin
                qi = sa / sb_;
                ri = sa % sb_;
            end
        end
        e.q = 32'(qi) & 32'hFF;
        e.r = 32'(ri) & 32'hFF;
        return e;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input int inject);
        exp_t e;
        int   n;
        bit   seen;
        sb.push_back(model8(a, b, sm));
        @(negedge clk);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done8) seen = 1;
            else begin
                if (busy8) n++;
                if (i == inject) begin
                    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h03; sm8 = 1'b1;
                end else begin
                    start8 = 1'b0;
                end
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            chk("timeout8", 32'd0, 32'd1);
            return;
        end
        chk("q8", {24'h0, q8}, e.q);
        chk("r8", {24'h0, r8}, e.r);
        chk("dz8", {31'h0, dz8}, {31'h0, e.dz});
        chk("busy8_len", 32'(n), 32'(e.busy));
        @(negedge clk);
        chk("done8_pulse", {31'h0, done8}, 32'd0);
        @(negedge clk);
        chk("idle8", {31'h0, busy8}, 32'd0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   n;
        bit   seen;
        e.q = {16'h0, a / b}; e.r = {16'h0, a % b}; e.dz = 1'b0; e.busy = 18;
        sb.push_back(e);
        @(negedge clk);
        a16 = a; b16 = b; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done16) seen = 1;
            else begin
                if (busy16) n++;
                @(negedge clk);
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            chk("timeout16", 32'd0, 32'd1);
            return;
        end
        chk("q16", {16'h0, q16}, e.q);
        chk("r16", {16'h0, r16}, e.r);
        chk("dz16", {31'h0, dz16}, 32'd0);
        chk("busy16_len", 32'(n), 32'(e.busy));
    endtask

    initial begin
        int dcnt;
        #1;
        chk("rst_q8", {24'h0, q8}, 32'd0);
        chk("rst_r8", {24'h0, r8}, 32'd0);
        chk("rst_busy8", {31'h0, busy8}, 32'd0);
        chk("rst_done8", {31'h0, done8}, 32'd0);
        chk("rst_dz8", {31'h0, dz8}, 32'd0);
        chk("rst_q16", {16'h0, q16}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run8(8'h55, 8'h05, 1'b0, -1);
        run8(8'h85, 8'h15, 1'b0, -1);
        run8(8'hFF, 8'h05, 1'b0, -1);
        run8(8'h83, 8'h0F, 1'b0, -1);
        run8(8'h99, 8'h0E, 1'b1, -1);
        run8(8'h80, 8'hFF, 1'b1, -1);
        run8(8'h55, 8'h00, 1'b0, -1);
        run8(8'hA5, 8'h00, 1'b1, -1);
        run8(8'h64, 8'hF9, 1'b1, -1);
        run8(8'h07, 8'h09, 1'b0, -1);
        // Start pulse mid-CALC must be ignored
        run8(8'h85, 8'h15, 1'b0, 4);
        for (int k = 0; k < 6; k++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
                 1'($urandom_range(0, 1)), -1);
        end

        run8(8'h83, 8'h0F, 1'b0, -1);
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h05; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_q8", {24'h0, q8}, 32'd0);
        chk("abort_r8", {24'h0, r8}, 32'd0);
        chk("abort_busy8", {31'h0, busy8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        chk("abort_nodone", 32'(dcnt), 32'd0);
        run8(8'h85, 8'h15, 1'b0, -1);

        run16(16'hFFFF, 16'h0003);
        run16(16'hBEEF, 16'h0123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
